// File: rtl/sr_flag_arbiter_if.sv
// ---------------------------------------------------------------------------
// sr_flag_arbiter_if
//   Bundles the request/grant signals of sr_flag_arbiter into one interface.
//   Clock and reset stay plain ports on the arbiter.
//
//   Parameters
//     N    number of requesters
//     IDW  width of grant_id
//
//   Signals
//     set_req     [N]    per-requester set pulse        (master -> slave)
//     cancel_req  [N]    per-requester cancel pulse     (master -> slave)
//     done        [1]    resource finished with grant   (master -> slave)
//     pending     [N]    registered pending flags       (slave -> master)
//     grant       [N]    one-hot grant                  (slave -> master)
//     grant_valid [1]    a grant is active              (slave -> master)
//     grant_id    [IDW]  index of active grant          (slave -> master)
//     timeout     [1]    forced-release pulse           (slave -> master)
//
//   Modports
//     master  request sources and shared datapath side
//     slave   the arbiter
// ---------------------------------------------------------------------------
interface sr_flag_arbiter_if #(
  parameter int N   = 4,
  parameter int IDW = 2
);
  logic [N-1:0]   set_req;
  logic [N-1:0]   cancel_req;
  logic           done;
  logic [N-1:0]   pending;
  logic [N-1:0]   grant;
  logic           grant_valid;
  logic [IDW-1:0] grant_id;
  logic           timeout;

  modport master (
    output set_req, cancel_req, done,
    input  pending, grant, grant_valid, grant_id, timeout
  );

  modport slave (
    input  set_req, cancel_req, done,
    output pending, grant, grant_valid, grant_id, timeout
  );
endinterface

// File: rtl/sr_flag_arbiter.sv
// ---------------------------------------------------------------------------
// sr_flag_arbiter
//   Round-robin scheduler sharing one downstream resource between N
//   requesters. Each requester owns an SR-style pending flag (S = set_req,
//   R = cancel_req). One pending requester is granted at a time and the
//   grant is held until done, a cancel of the granted index, or (optionally)
//   a timeout. Every grant returns through IDLE before the next one.
//
//   Parameters
//     N          number of requesters (2..8)
//     IDW        width of grant_id, 2**IDW >= N
//     TO_CYCLES  grant timeout in cycles (only with SR_ARB_TIMEOUT_EN)
//
//   Ports
//     clk    rising-edge clock
//     reset  asynchronous, active-low reset
//     bus    sr_flag_arbiter_if.slave: set_req, cancel_req, done in;
//            pending, grant, grant_valid, grant_id, timeout out
//
//   Configuration
//     SR_ARB_TIMEOUT_EN  when defined, a per-grant cycle counter force-
//                        releases a grant after TO_CYCLES cycles and pulses
//                        timeout; when undefined, timeout is tied 0 and no
//                        counter is built.
// ---------------------------------------------------------------------------
module sr_flag_arbiter #(
  parameter int N         = 4,
  parameter int IDW       = 2,
  parameter int TO_CYCLES = 16
) (
  input  logic               clk,
  input  logic               reset,
  sr_flag_arbiter_if.slave   bus
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  logic [0:0]     state_q,       state_d;
  logic [N-1:0]   pending_q,     pending_d;
  logic [N-1:0]   grant_q,       grant_d;
  logic           grant_valid_q, grant_valid_d;
  logic [IDW-1:0] grant_id_q,    grant_id_d;
  logic [IDW-1:0] last_id_q,     last_id_d;

  logic           sel_found;
  logic [IDW-1:0] sel_id;
  logic           in_grant;
  logic           cancel_rel;
  logic           to_hit;
  logic           release_now;

`ifdef SR_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TO_CYCLES) + 1;
  logic [CW-1:0] cnt_q, cnt_d;
`endif

  // -------------------------------------------------------------------------
  // Round-robin search over the registered pending flags, starting just
  // after the last released index.
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable written here gets a default first so that no
    // path leaves it unassigned, which would infer a latch.
    sel_found = 1'b0;
    sel_id    = '0;
    for (int k = 1; k <= N; k++) begin
      logic [IDW-1:0] idx;
      idx = IDW'((int'(last_id_q) + k) % N);
      if (!sel_found && pending_q[idx]) begin
        sel_found = 1'b1;
        sel_id    = idx;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Release conditions for the active grant.
  // -------------------------------------------------------------------------
  always_comb begin
    in_grant   = (state_q == ST_GRANT);
    // A cancel of the granted index only releases if it is not also being
    // re-set in the same cycle (set+cancel together is a no-change).
    cancel_rel = in_grant && bus.cancel_req[grant_id_q] && !bus.set_req[grant_id_q];
`ifdef SR_ARB_TIMEOUT_EN
    // done or a cancel release in the same cycle takes precedence, so the
    // timeout pulse stays low then.
    to_hit     = in_grant && (cnt_q == CW'(TO_CYCLES - 1)) && !bus.done && !cancel_rel;
`else
    to_hit     = 1'b0;
`endif
    release_now = in_grant && (bus.done || cancel_rel || to_hit);
  end

  // -------------------------------------------------------------------------
  // Pending flags: set wins, cancel clears, both together hold, otherwise
  // the flag is cleared when its index is released this cycle.
  // -------------------------------------------------------------------------
  always_comb begin
    pending_d = pending_q;
    for (int i = 0; i < N; i++) begin
      unique case ({bus.set_req[i], bus.cancel_req[i]})
        2'b10:   pending_d[i] = 1'b1;
        2'b01:   pending_d[i] = 1'b0;
        2'b11:   pending_d[i] = pending_q[i];
        default: if (release_now && (grant_id_q == IDW'(i))) pending_d[i] = 1'b0;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Two-state FSM: IDLE arbitrates, GRANT holds until release.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    grant_valid_d = grant_valid_q;
    grant_id_d    = grant_id_q;
    last_id_d     = last_id_q;
    unique case (state_q)
      ST_IDLE: begin
        if (sel_found) begin
          grant_d       = {{(N-1){1'b0}}, 1'b1} << sel_id;
          grant_id_d    = sel_id;
          grant_valid_d = 1'b1;
          state_d       = ST_GRANT;
        end
      end
      default: begin
        if (release_now) begin
          grant_d       = '0;
          grant_id_d    = '0;
          grant_valid_d = 1'b0;
          last_id_d     = grant_id_q;
          state_d       = ST_IDLE;
        end
      end
    endcase
  end

`ifdef SR_ARB_TIMEOUT_EN
  // Cleared on entry to GRANT, so the first GRANT cycle sees count 0.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_IDLE) cnt_d = '0;
    else                    cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: state uses non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    if (!reset) begin
      state_q       <= ST_IDLE;
      pending_q     <= '0;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      grant_id_q    <= '0;
      // Start one below index 0 so the first search begins at requester 0.
      last_id_q     <= IDW'(N - 1);
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      grant_q       <= grant_d;
      grant_valid_q <= grant_valid_d;
      grant_id_q    <= grant_id_d;
      last_id_q     <= last_id_d;
    end
  end

  assign bus.pending     = pending_q;
  assign bus.grant       = grant_q;
  assign bus.grant_valid = grant_valid_q;
  assign bus.grant_id    = grant_id_q;
  assign bus.timeout     = to_hit;

endmodule
